// File: rtl/alu_rs_scheduler.sv
// Reservation station and one-wide issue scheduler for the integer ALU, with wakeup from two CDB ports.
// Optional RS_BYPASS_EN sends a ready dispatch straight to the issue registers when no entry is ready.
module alu_rs_scheduler #(
    parameter int RS_DEPTH = 8,
    parameter int ROB_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             dsp_valid,
    input  logic [5:0]       dsp_opcode,
    input  logic             dsp_qj_busy,
    input  logic [ROB_W-1:0] dsp_qj,
    input  logic [31:0]      dsp_vj,
    input  logic             dsp_qk_busy,
    input  logic [ROB_W-1:0] dsp_qk,
    input  logic [31:0]      dsp_vk,
    input  logic [31:0]      dsp_imm,
    input  logic [31:0]      dsp_pc,
    input  logic [ROB_W-1:0] dsp_rob,
    output logic             rs_full,
    input  logic             cdb0_valid,
    input  logic [ROB_W-1:0] cdb0_rob,
    input  logic [31:0]      cdb0_value,
    input  logic             cdb1_valid,
    input  logic [ROB_W-1:0] cdb1_rob,
    input  logic [31:0]      cdb1_value,
    output logic             alu_sgn,
    output logic [5:0]       alu_opcode,
    output logic [31:0]      alu_lhs,
    output logic [31:0]      alu_rhs,
    output logic [31:0]      alu_imm,
    output logic [31:0]      alu_pc,
    output logic [ROB_W-1:0] alu_rob
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic             busy;
        logic [5:0]       op;
        logic             qj_busy;
        logic [ROB_W-1:0] qj;
        logic [31:0]      vj;
        logic             qk_busy;
        logic [ROB_W-1:0] qk;
        logic [31:0]      vk;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [ROB_W-1:0] rob;
    } ent_t;

    ent_t             ent_q [RS_DEPTH];
    ent_t             ent_d [RS_DEPTH];
    ent_t             new_ent;
    logic [CNT_W-1:0] count_q, count_d;
    logic             alu_sgn_q, alu_sgn_d;
    ent_t             alu_q, alu_d;
    logic             sel_vld, free_vld, alloc, issue;
    logic [IDX_W-1:0] sel_idx, free_idx;

    // Returns {still_busy, value}; CDB0 takes precedence when both ports carry the tag.
    function automatic logic [32:0] wake(input logic busy, input logic [ROB_W-1:0] tag,
                                         input logic [31:0] val);
        if (busy && cdb0_valid && tag == cdb0_rob)
            return {1'b0, cdb0_value};
        else if (busy && cdb1_valid && tag == cdb1_rob)
            return {1'b0, cdb1_value};
        else
            return {busy, val};
    endfunction

    always_comb begin
        ent_d     = ent_q;
        count_d   = count_q;
        alu_sgn_d = alu_sgn_q;
        alu_d     = alu_q;
        sel_vld   = 1'b0;
        sel_idx   = '0;
        free_vld  = 1'b0;
        free_idx  = '0;
        alloc     = 1'b0;
        issue     = 1'b0;

        // Descending scan so the lowest index wins.
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].busy && !ent_q[i].qj_busy && !ent_q[i].qk_busy) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
            if (!ent_q[i].busy) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
        end

        new_ent     = '{busy: 1'b1, op: dsp_opcode, qj_busy: dsp_qj_busy, qj: dsp_qj, vj: dsp_vj,
                        qk_busy: dsp_qk_busy, qk: dsp_qk, vk: dsp_vk, imm: dsp_imm, pc: dsp_pc,
                        rob: dsp_rob};
        {new_ent.qj_busy, new_ent.vj} = wake(dsp_qj_busy, dsp_qj, dsp_vj);
        {new_ent.qk_busy, new_ent.vk} = wake(dsp_qk_busy, dsp_qk, dsp_vk);

        if (rdy) begin
            alu_sgn_d = 1'b0;
            if (flush) begin
                for (int i = 0; i < RS_DEPTH; i++) ent_d[i].busy = 1'b0;
                count_d = '0;
            end else begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (ent_q[i].busy) begin
                        {ent_d[i].qj_busy, ent_d[i].vj} = wake(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
                        {ent_d[i].qk_busy, ent_d[i].vk} = wake(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk);
                    end
                end
                // Selection uses registered readiness: a wakeup edge issues on the following edge.
                if (sel_vld) begin
                    issue                = 1'b1;
                    ent_d[sel_idx].busy  = 1'b0;
                    alu_d                = ent_q[sel_idx];
                    alu_sgn_d            = 1'b1;
                end
                if (dsp_valid && !rs_full) begin
`ifdef RS_BYPASS_EN
                    if (!sel_vld && !new_ent.qj_busy && !new_ent.qk_busy) begin
                        alu_d     = new_ent;
                        alu_sgn_d = 1'b1;
                    end else begin
                        alloc = free_vld;
                    end
`else
                    alloc = free_vld;
`endif
                    if (alloc) ent_d[free_idx] = new_ent;
                end
                count_d = count_q + CNT_W'(alloc) - CNT_W'(issue);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
            count_q   <= '0;
            alu_sgn_q <= 1'b0;
            alu_q     <= '0;
        end else begin
            ent_q     <= ent_d;
            count_q   <= count_d;
            alu_sgn_q <= alu_sgn_d;
            alu_q     <= alu_d;
        end
    end

    // Gating keeps a frozen pipeline from seeing the same issue twice.
    assign alu_sgn    = alu_sgn_q & rdy;
    assign rs_full    = (count_q == CNT_W'(RS_DEPTH));
    assign alu_opcode = alu_q.op;
    assign alu_lhs    = alu_q.vj;
    assign alu_rhs    = alu_q.vk;
    assign alu_imm    = alu_q.imm;
    assign alu_pc     = alu_q.pc;
    assign alu_rob    = alu_q.rob;
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler (default build, no bypass): issue latency, wakeup, full, select order, flush, freeze.
module tb_alu_rs_scheduler;
    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        dsp_valid, dsp_qj_busy, dsp_qk_busy;
    logic [5:0]  dsp_opcode;
    logic [3:0]  dsp_qj, dsp_qk, dsp_rob;
    logic [31:0] dsp_vj, dsp_vk, dsp_imm, dsp_pc;
    logic        rs_full;
    logic        cdb0_valid, cdb1_valid;
    logic [3:0]  cdb0_rob, cdb1_rob;
    logic [31:0] cdb0_value, cdb1_value;
    logic        alu_sgn;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_lhs, alu_rhs, alu_imm, alu_pc;
    logic [3:0]  alu_rob;

    int n_checks = 0;
    int n_fail   = 0;

    alu_rs_scheduler #(.RS_DEPTH(8), .ROB_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .dsp_valid(dsp_valid), .dsp_opcode(dsp_opcode),
        .dsp_qj_busy(dsp_qj_busy), .dsp_qj(dsp_qj), .dsp_vj(dsp_vj),
        .dsp_qk_busy(dsp_qk_busy), .dsp_qk(dsp_qk), .dsp_vk(dsp_vk),
        .dsp_imm(dsp_imm), .dsp_pc(dsp_pc), .dsp_rob(dsp_rob), .rs_full(rs_full),
        .cdb0_valid(cdb0_valid), .cdb0_rob(cdb0_rob), .cdb0_value(cdb0_value),
        .cdb1_valid(cdb1_valid), .cdb1_rob(cdb1_rob), .cdb1_value(cdb1_value),
        .alu_sgn(alu_sgn), .alu_opcode(alu_opcode), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob(alu_rob)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [5:0] op, input logic jb, input logic [3:0] qj,
                            input logic [31:0] vj, input logic kb, input logic [3:0] qk,
                            input logic [31:0] vk, input logic [3:0] rob);
        dsp_valid = 1'b1; dsp_opcode = op;
        dsp_qj_busy = jb; dsp_qj = qj; dsp_vj = vj;
        dsp_qk_busy = kb; dsp_qk = qk; dsp_vk = vk;
        dsp_imm = 32'h100 + 32'(rob); dsp_pc = 32'h1000 + 32'(rob); dsp_rob = rob;
        tick();
        dsp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        dsp_valid = 1'b0; dsp_opcode = '0; dsp_qj_busy = 1'b0; dsp_qj = '0; dsp_vj = '0;
        dsp_qk_busy = 1'b0; dsp_qk = '0; dsp_vk = '0; dsp_imm = '0; dsp_pc = '0; dsp_rob = '0;
        cdb0_valid = 1'b0; cdb0_rob = '0; cdb0_value = '0;
        cdb1_valid = 1'b0; cdb1_rob = '0; cdb1_value = '0;
        tick(); tick();
        check("reset_sgn", 32'(alu_sgn), 32'd0);
        check("reset_full", 32'(rs_full), 32'd0);
        check("reset_lhs", alu_lhs, 32'd0);
        check("reset_rob", 32'(alu_rob), 32'd0);
        rst = 1'b0;
        tick();

        // 1: ready ADD issues two edges after dispatch
        dispatch(6'd1, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3);
        check("t1_no_early_sgn", 32'(alu_sgn), 32'd0);
        tick();
        check("t1_sgn", 32'(alu_sgn), 32'd1);
        check("t1_lhs", alu_lhs, 32'd5);
        check("t1_rhs", alu_rhs, 32'd7);
        check("t1_rob", 32'(alu_rob), 32'd3);
        check("t1_op", 32'(alu_opcode), 32'd1);
        check("t1_pc", alu_pc, 32'h1003);
        tick();
        check("t1_sgn_one_cycle", 32'(alu_sgn), 32'd0);

        // 2: lhs pending on tag 2, woken by CDB1
        dispatch(6'd2, 1'b1, 4'd2, 32'd0, 1'b0, 4'd0, 32'd1, 4'd4);
        tick();
        check("t2_wait_a", 32'(alu_sgn), 32'd0);
        tick();
        check("t2_wait_b", 32'(alu_sgn), 32'd0);
        cdb1_valid = 1'b1; cdb1_rob = 4'd2; cdb1_value = 32'h10;
        tick();
        cdb1_valid = 1'b0;
        check("t2_wake_edge_no_sgn", 32'(alu_sgn), 32'd0);
        tick();
        check("t2_sgn", 32'(alu_sgn), 32'd1);
        check("t2_lhs", alu_lhs, 32'h10);
        check("t2_rob", 32'(alu_rob), 32'd4);

        // 3: same-cycle CDB0 forwarding into the dispatched entry
        cdb0_valid = 1'b1; cdb0_rob = 4'd6; cdb0_value = 32'hAB;
        dispatch(6'd3, 1'b0, 4'd0, 32'd1, 1'b1, 4'd6, 32'd0, 4'd7);
        cdb0_valid = 1'b0;
        tick();
        check("t3_sgn", 32'(alu_sgn), 32'd1);
        check("t3_rhs", alu_rhs, 32'hAB);
        check("t3_rob", 32'(alu_rob), 32'd7);

        // 4: fill 8 pending entries (entry i waits on tag 8+i)
        for (int i = 0; i < 8; i++) begin
            dispatch(6'd4, 1'b1, 4'(8 + i), 32'd0, 1'b0, 4'd0, 32'(i), 4'(i));
            check($sformatf("t4_full_%0d", i), 32'(rs_full), (i == 7) ? 32'd1 : 32'd0);
        end
        dispatch(6'd5, 1'b0, 4'd0, 32'h99, 1'b0, 4'd0, 32'h99, 4'd15);
        check("t4_full_after_9th", 32'(rs_full), 32'd1);
        check("t4_9th_no_sgn", 32'(alu_sgn), 32'd0);
        cdb0_valid = 1'b1; cdb0_rob = 4'd13; cdb0_value = 32'h55;
        tick();
        cdb0_valid = 1'b0;
        tick();
        check("t4_sgn", 32'(alu_sgn), 32'd1);
        check("t4_rob", 32'(alu_rob), 32'd5);
        check("t4_lhs", alu_lhs, 32'h55);
        check("t4_full_cleared", 32'(rs_full), 32'd0);

        // 5: entries 1 and 4 ready on the same edge
        cdb0_valid = 1'b1; cdb0_rob = 4'd9;  cdb0_value = 32'h91;
        cdb1_valid = 1'b1; cdb1_rob = 4'd12; cdb1_value = 32'hC4;
        tick();
        cdb0_valid = 1'b0; cdb1_valid = 1'b0;
        tick();
        check("t5_first_rob", 32'(alu_rob), 32'd1);
        check("t5_first_lhs", alu_lhs, 32'h91);
        tick();
        check("t5_second_sgn", 32'(alu_sgn), 32'd1);
        check("t5_second_rob", 32'(alu_rob), 32'd4);
        check("t5_second_lhs", alu_lhs, 32'hC4);
        tick();
        check("t5_idle", 32'(alu_sgn), 32'd0);

        // CDB0 wins when both ports carry tag 8 (entry 0)
        cdb0_valid = 1'b1; cdb0_rob = 4'd8; cdb0_value = 32'hA0;
        cdb1_valid = 1'b1; cdb1_rob = 4'd8; cdb1_value = 32'hB0;
        tick();
        cdb0_valid = 1'b0; cdb1_valid = 1'b0;
        tick();
        check("prio_rob", 32'(alu_rob), 32'd0);
        check("prio_lhs", alu_lhs, 32'hA0);

        // 6: flush with entries 2,3,6,7 busy plus a ready dispatch
        flush = 1'b1;
        dispatch(6'd6, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 4'd9);
        flush = 1'b0;
        check("t6_flush_sgn", 32'(alu_sgn), 32'd0);
        cdb0_valid = 1'b1; cdb0_rob = 4'd10; cdb0_value = 32'h1;
        cdb1_valid = 1'b1; cdb1_rob = 4'd11; cdb1_value = 32'h2;
        tick();
        cdb0_valid = 1'b0; cdb1_valid = 1'b0;
        check("t6_no_sgn_a", 32'(alu_sgn), 32'd0);
        tick();
        check("t6_no_sgn_b", 32'(alu_sgn), 32'd0);
        for (int i = 0; i < 8; i++) begin
            dispatch(6'd7, 1'b1, 4'(i), 32'd0, 1'b0, 4'd0, 32'd0, 4'(i));
            check($sformatf("t6_refill_full_%0d", i), 32'(rs_full), (i == 7) ? 32'd1 : 32'd0);
        end

        // rdy low: CDB ignored, no issue
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cdb0_valid = 1'b1; cdb0_rob = 4'd0; cdb0_value = 32'h11;
            tick();
            check($sformatf("frz_sgn_%0d", i), 32'(alu_sgn), 32'd0);
        end
        cdb0_valid = 1'b0;
        rdy = 1'b1;
        tick();
        tick();
        check("frz_cdb_ignored", 32'(alu_sgn), 32'd0);
        cdb0_valid = 1'b1; cdb0_rob = 4'd1; cdb0_value = 32'h22;
        tick();
        cdb0_valid = 1'b0;
        tick();
        check("frz_wake_sgn", 32'(alu_sgn), 32'd1);
        check("frz_wake_lhs", alu_lhs, 32'h22);
        rdy = 1'b0;
        #1;
        check("frz_gated_sgn", 32'(alu_sgn), 32'd0);
        rdy = 1'b1;
        #1;
        check("frz_ungated_sgn", 32'(alu_sgn), 32'd1);

        // asynchronous reset from a full RS
        tick();
        dispatch(6'd8, 1'b1, 4'd15, 32'd0, 1'b0, 4'd0, 32'd0, 4'd9);
        check("rst_pre_full", 32'(rs_full), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_full", 32'(rs_full), 32'd0);
        check("rst_async_rob", 32'(alu_rob), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
